dense_requant_relu: RTL

//   Sits directly downstream of dense_25D. Takes one 32-bit accumulator per tree per window and produces one 8-bit pixel per tree.
//   Per-tree datapath: bias add, rounding arithmetic right shift, ReLU, saturation.
//   The 8-bit result feeds the next layer's pixel input.

---
 rtl/dense_requant_relu_pkg.sv | 16 +
 rtl/dense_requant_relu_lane.sv | 45 ++++
 rtl/dense_requant_relu.sv | 82 ++++++++
 3 files changed

// File: rtl/dense_requant_relu_pkg.sv
// Shared widths, lane word types and the rounding helper for the dense requantisation path.
package dense_pkg;

  localparam int ACC_WIDTH = 32;
  localparam int PIX_WIDTH = 8;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic        [PIX_WIDTH-1:0] pix_t;

  // Half-up rounding offset added before the arithmetic shift; zero shift means no rounding.
  function automatic logic signed [ACC_WIDTH+1:0] ROUND_CONST(input int shift);
    if (shift == 0) return '0;
    return (ACC_WIDTH+2)'(1) << (shift - 1);
  endfunction

endpackage

// File: rtl/dense_requant_relu_lane.sv
// One tree's requantisation datapath: bias add, rounding shift, ReLU with upper clamp.
module requant_lane
  import dense_pkg::*;
#(
  parameter int SHIFT   = 4,
  parameter int SAT_MAX = 127
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        en,
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [ACC_WIDTH-1:0] bias,
  output logic        [PIX_WIDTH-1:0] pix
);

  localparam logic signed [ACC_WIDTH+1:0] SAT_LIM = (ACC_WIDTH+2)'(SAT_MAX);

  function automatic logic [PIX_WIDTH-1:0] relu_sat(input logic signed [ACC_WIDTH+1:0] r);
    if (r[ACC_WIDTH+1]) return '0;
    if (r > SAT_LIM) return PIX_WIDTH'(SAT_MAX);
    return r[PIX_WIDTH-1:0];
  endfunction

  logic signed [ACC_WIDTH:0]   sum_p0;
  logic signed [ACC_WIDTH+1:0] rnd;
  logic signed [ACC_WIDTH+1:0] shr_p1;
  logic        [PIX_WIDTH-1:0] pix_p2;

  assign rnd = {sum_p0[ACC_WIDTH], sum_p0} + ROUND_CONST(SHIFT);
  assign pix = pix_p2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_p0 <= '0;
      shr_p1 <= '0;
      pix_p2 <= '0;
    end else if (en) begin
      // p0: bias add, p1: rounding shift, p2: ReLU and clamp
      sum_p0 <= {acc[ACC_WIDTH-1], acc} + {bias[ACC_WIDTH-1], bias};
      shr_p1 <= rnd >>> SHIFT;
      pix_p2 <= relu_sat(shr_p1);
    end
  end

endmodule

// File: rtl/dense_requant_relu.sv
// Requantises dense_25D accumulators to 8-bit pixels behind a stallable 3-stage pipeline with a frame window counter.
module dense_requant_relu
  import dense_pkg::*;
#(
  parameter int NUM_TREES         = 2,
  parameter int SHIFT             = 4,
  parameter int SAT_MAX           = 127,
  parameter int WINDOWS_PER_FRAME = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [ACC_WIDTH*NUM_TREES-1:0]       pixel_vector_in,
  input  logic [ACC_WIDTH*NUM_TREES-1:0]       bias,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [PIX_WIDTH*NUM_TREES-1:0]       pixel_vector_out,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic [$clog2(WINDOWS_PER_FRAME):0]   window_count
);

  localparam int CW = $clog2(WINDOWS_PER_FRAME) + 1;
  localparam logic [CW-1:0] LAST_WIN = CW'(WINDOWS_PER_FRAME - 1);

  typedef acc_t [NUM_TREES-1:0] acc_vec_t;
  typedef pix_t [NUM_TREES-1:0] pix_vec_t;

  acc_vec_t acc_v;
  acc_vec_t bias_v;
  pix_vec_t pix_v;

  logic adv;
  logic vld_p0, vld_p1, vld_p2;
  logic [CW-1:0] win_cnt;

  assign acc_v  = pixel_vector_in;
  assign bias_v = bias;

  // Every stage shares one enable, so a stall freezes data and valids together.
  assign adv              = ~vld_p2 | out_ready;
  assign in_ready         = adv;
  assign out_valid        = vld_p2;
  assign out_last         = vld_p2 & (win_cnt == LAST_WIN);
  assign window_count     = win_cnt;
  assign pixel_vector_out = pix_v;

  for (genvar t = 0; t < NUM_TREES; t++) begin : g_lane
    requant_lane #(
      .SHIFT   (SHIFT),
      .SAT_MAX (SAT_MAX)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .en    (adv),
      .acc   (acc_v[t]),
      .bias  (bias_v[t]),
      .pix   (pix_v[t])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt <= '0;
    end else if (vld_p2 & out_ready) begin
      win_cnt <= (win_cnt == LAST_WIN) ? '0 : win_cnt + 1'b1;
    end
  end

endmodule
